// File: rtl/uart_tx_scheduler_if.sv
// Bus between the log FIFO / uart_tx side and the scheduler.
// slave is the scheduler view, master is the FIFO+UART (or bench) view.
interface uart_tx_scheduler_if #(
  parameter int OVF_CNT_W = 16
);
  logic                 i_enable;
  logic                 i_fifo_empty;
  logic                 o_fifo_ren;
  logic [7:0]           i_fifo_rdata;
  logic                 i_fifo_full;
  logic                 i_fifo_wen;
  logic                 o_tx_valid;
  logic [7:0]           o_tx_data;
  logic                 i_tx_ready;
  logic [OVF_CNT_W-1:0] o_ovf_cnt;
  logic                 o_busy;

  modport slave (
    input  i_enable, i_fifo_empty, i_fifo_rdata, i_fifo_full, i_fifo_wen, i_tx_ready,
    output o_fifo_ren, o_tx_valid, o_tx_data, o_ovf_cnt, o_busy
  );

  modport master (
    output i_enable, i_fifo_empty, i_fifo_rdata, i_fifo_full, i_fifo_wen, i_tx_ready,
    input  o_fifo_ren, o_tx_valid, o_tx_data, o_ovf_cnt, o_busy
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Drains the log FIFO into uart_tx one byte per handshake and counts FIFO overflow drops.
// Define UART_TX_OVF_MSG_EN to insert a "!OVF HH\r\n" report line after drops.
module uart_tx_scheduler #(
  parameter int FIFO_RD_LAT = 1,
  parameter int OVF_CNT_W   = 16
) (
  input logic                i_clk,
  input logic                i_res_n,
  uart_tx_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, CAP, RPT, SEND} state_t;
  localparam logic [1:0] WAIT_LAST = 2'(FIFO_RD_LAT - 2);

  state_t               state, state_nxt;
  logic [1:0]           wait_cnt;
  logic [7:0]           tx_data, rpt_byte;
  logic [OVF_CNT_W-1:0] ovf_cnt, ovf_base, ovf_nxt;
  logic                 accept, ovf_clr, rd_go, rpt_go, rpt_more;

  assign accept = (state == SEND) && bus.i_tx_ready;

`ifdef UART_TX_OVF_MSG_EN
  logic       rpt_active, last_lf;
  logic [3:0] rpt_idx;
  logic [7:0] rpt_hh;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    case (rpt_idx)
      4'd0:    rpt_byte = 8'h21;
      4'd1:    rpt_byte = 8'h4F;
      4'd2:    rpt_byte = 8'h56;
      4'd3:    rpt_byte = 8'h46;
      4'd4:    rpt_byte = 8'h20;
      4'd5:    rpt_byte = hex_char(rpt_hh[7:4]);
      4'd6:    rpt_byte = hex_char(rpt_hh[3:0]);
      4'd7:    rpt_byte = 8'h0D;
      default: rpt_byte = 8'h0A;
    endcase
  end

  // A report only starts on a line boundary, or when the FIFO has nothing left to finish the line.
  assign rpt_go   = bus.i_enable && (ovf_cnt != '0) && (last_lf || bus.i_fifo_empty);
  assign rpt_more = rpt_active && (rpt_idx != 4'd8);
  assign ovf_clr  = accept && rpt_active && (rpt_idx == 4'd0);

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      rpt_active <= 1'b0;
      rpt_idx    <= 4'd0;
      rpt_hh     <= 8'h00;
      last_lf    <= 1'b1;
    end else begin
      if (state == IDLE && rpt_go) begin
        rpt_active <= 1'b1;
        rpt_idx    <= 4'd0;
        rpt_hh     <= (ovf_cnt > OVF_CNT_W'(255)) ? 8'hFF : ovf_cnt[7:0];
      end else if (accept && rpt_active) begin
        if (rpt_more) rpt_idx <= rpt_idx + 4'd1;
        else          rpt_active <= 1'b0;
      end
      if (accept) last_lf <= (tx_data == 8'h0A);
    end
  end
`else
  assign rpt_byte = 8'h00;
  assign rpt_go   = 1'b0;
  assign rpt_more = 1'b0;
  assign ovf_clr  = 1'b0;
`endif

  assign rd_go = bus.i_enable && !bus.i_fifo_empty && !rpt_go;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rpt_go) state_nxt = RPT;
               else if (rd_go) state_nxt = RD;
      RD:      state_nxt = (FIFO_RD_LAT == 1) ? CAP : WAIT;
      WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = CAP;
      CAP:     state_nxt = SEND;
      RPT:     state_nxt = SEND;
      SEND:    if (bus.i_tx_ready) state_nxt = rpt_more ? RPT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear happens before the increment so a same-cycle drop is not lost.
  always_comb begin
    ovf_base = ovf_clr ? '0 : ovf_cnt;
    ovf_nxt  = ovf_base;
    if (bus.i_fifo_wen && bus.i_fifo_full && (ovf_base != '1))
      ovf_nxt = ovf_base + OVF_CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
      tx_data  <= 8'h00;
      ovf_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
      if (state == CAP)      tx_data <= bus.i_fifo_rdata;
      else if (state == RPT) tx_data <= rpt_byte;
      ovf_cnt  <= ovf_nxt;
    end
  end

  assign bus.o_fifo_ren = (state == RD);
  assign bus.o_tx_valid = (state == SEND);
  assign bus.o_tx_data  = tx_data;
  assign bus.o_ovf_cnt  = ovf_cnt;
  assign bus.o_busy     = (state != IDLE);
endmodule
